// File: rtl/register_bank.sv
// register_bank: 32x32 MIPS register file, two combinational read ports, one
// synchronous write port, hardwired r0 and WB->ID write-through bypass.
module register_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  input  logic [ADDR_WIDTH-1:0] selReadReg1,
  input  logic [ADDR_WIDTH-1:0] selReadReg2,
  input  logic [ADDR_WIDTH-1:0] selWriteReg,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  enWriteReg
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  doWrite;
  logic                  bypass1;
  logic                  bypass2;
  assign doWrite = enWriteReg && selWriteReg != '0;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (doWrite) begin
      regs[selWriteReg] <= WriteData;
    end
  end
  // Bypass is off during reset so reads see the cleared file, not WriteData.
  assign bypass1 = !reset && doWrite && selWriteReg == selReadReg1;
  assign bypass2 = !reset && doWrite && selWriteReg == selReadReg2;
  always_comb begin
    ReadData1 = selReadReg1 == '0 ? '0 : bypass1 ? WriteData : regs[selReadReg1];
    ReadData2 = selReadReg2 == '0 ? '0 : bypass2 ? WriteData : regs[selReadReg2];
  end
endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: directed table-driven checks of register_bank plus
// hand-written sweep, overwrite and asynchronous-reset sequences.
module tb_register_bank;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [4:0]  selReadReg1 = '0;
  logic [4:0]  selReadReg2 = '0;
  logic [4:0]  selWriteReg = '0;
  logic [31:0] WriteData = '0;
  logic        enWriteReg = 1'b0;
  int          tests = 0;
  int          failed = 0;

  register_bank dut (
    .clock(clock),
    .reset(reset),
    .ReadData1(ReadData1),
    .ReadData2(ReadData2),
    .selReadReg1(selReadReg1),
    .selReadReg2(selReadReg2),
    .selWriteReg(selWriteReg),
    .WriteData(WriteData),
    .enWriteReg(enWriteReg)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [4:0]  ws;
    logic [31:0] wd;
    logic        en;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] ws,
                       input logic [31:0] wd, input logic en);
    selReadReg1 = s1;
    selReadReg2 = s2;
    selWriteReg = ws;
    WriteData   = wd;
    enWriteReg  = en;
  endtask

  function automatic logic [31:0] sweepVal(input int i);
    return i == 0 ? 32'd0 : 32'(i * 3 + 1);
  endfunction

  initial begin
    vecs[0] = '{5'd1, 5'd2, 5'd2, 32'd25,        1'b1, 32'd0,        32'd25};
    vecs[1] = '{5'd1, 5'd2, 5'd0, 32'd0,         1'b0, 32'd0,        32'd25};
    vecs[2] = '{5'd5, 5'd2, 5'd5, 32'hDEADBEEF,  1'b0, 32'd0,        32'd25};
    vecs[3] = '{5'd5, 5'd5, 5'd0, 32'd0,         1'b0, 32'd0,        32'd0};
    vecs[4] = '{5'd0, 5'd0, 5'd0, 32'hFFFFFFFF,  1'b1, 32'd0,        32'd0};
    vecs[5] = '{5'd0, 5'd2, 5'd0, 32'd0,         1'b0, 32'd0,        32'd25};
    vecs[6] = '{5'd9, 5'd9, 5'd9, 32'hA5A5A5A5,  1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[7] = '{5'd9, 5'd2, 5'd2, 32'd77,        1'b1, 32'hA5A5A5A5, 32'd77};
    vecs[8] = '{5'd2, 5'd9, 5'd0, 32'd0,         1'b0, 32'd77,       32'hA5A5A5A5};

    // reset held two cycles; a would-be write must neither bypass nor land
    drive(5'd1, 5'd2, 5'd1, 32'h11111111, 1'b1);
    repeat (2) @(posedge clock);
    #1;
    chk("reset_rd1", ReadData1, 32'd0);
    chk("reset_rd2", ReadData2, 32'd0);
    drive(5'd1, 5'd2, 5'd0, 32'd0, 1'b0);
    reset = 1'b0;
    #2;
    chk("post_reset_rd1", ReadData1, 32'd0);

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].s1, vecs[i].s2, vecs[i].ws, vecs[i].wd, vecs[i].en);
      #2;
      chk($sformatf("vec%0d_rd1", i), ReadData1, vecs[i].e1);
      chk($sformatf("vec%0d_rd2", i), ReadData2, vecs[i].e2);
      @(posedge clock);
      #1;
    end

    for (int i = 1; i < 32; i++) begin
      drive(5'd0, 5'd0, 5'(i), sweepVal(i), 1'b1);
      @(posedge clock);
      #1;
    end
    enWriteReg = 1'b0;
    for (int i = 0; i < 32; i++) begin
      selReadReg1 = 5'(i);
      selReadReg2 = 5'(31 - i);
      #1;
      chk($sformatf("sweep_rd1_r%0d", i), ReadData1, sweepVal(i));
      chk($sformatf("sweep_rd2_r%0d", 31 - i), ReadData2, sweepVal(31 - i));
    end

    @(posedge clock);
    #1;
    drive(5'd7, 5'd8, 5'd7, 32'h12345678, 1'b1);
    @(posedge clock);
    #1;
    drive(5'd7, 5'd8, 5'd7, 32'h0BADF00D, 1'b1);
    @(posedge clock);
    #1;
    enWriteReg = 1'b0;
    #1;
    chk("overwrite_r7", ReadData1, 32'h0BADF00D);
    chk("overwrite_r8", ReadData2, sweepVal(8));

    // async reset pulse in the clock-high phase, no edge until it drops
    @(posedge clock);
    #1;
    drive(5'd7, 5'd20, 5'd0, 32'd0, 1'b0);
    reset = 1'b1;
    #1;
    chk("async_rst_r7", ReadData1, 32'd0);
    chk("async_rst_r20", ReadData2, 32'd0);
    #4;
    reset = 1'b0;
    #1;
    chk("after_pulse_r7", ReadData1, 32'd0);
    chk("after_pulse_r20", ReadData2, 32'd0);
    @(posedge clock);
    #1;
    for (int i = 0; i < 32; i++) begin
      selReadReg1 = 5'(i);
      selReadReg2 = 5'(31 - i);
      #1;
      chk($sformatf("cleared_rd1_r%0d", i), ReadData1, 32'd0);
      chk($sformatf("cleared_rd2_r%0d", 31 - i), ReadData2, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
- 32-entry x 32-bit general-purpose register file for the pipelined MIPS datapath.
- Two combinational read ports feed the ID stage; one synchronous write port is driven from the WB stage.
- Register 0 is hardwired to zero.
- Internal write-through bypass: a WB write is visible to an ID read in the same cycle.

Parameters:
- DATA_WIDTH, 32, width of each register and data port
- ADDR_WIDTH, 5, register select width; depth = 2**ADDR_WIDTH (32)

Ports:
- clock  input  1  system clock; all writes on rising edge
- reset  input  1  asynchronous, active-high; clears all registers
- ReadData1  output  DATA_WIDTH  contents of register selReadReg1 (bypassed)
- ReadData2  output  DATA_WIDTH  contents of register selReadReg2 (bypassed)
- selReadReg1  input  ADDR_WIDTH  read port 1 register index
- selReadReg2  input  ADDR_WIDTH  read port 2 register index
- selWriteReg  input  ADDR_WIDTH  write port register index
- WriteData  input  DATA_WIDTH  data to write
- enWriteReg  input  1  write enable, active-high

Behaviour:
- Storage: registers r0..r31, each DATA_WIDTH bits.
- Reset:
  - reset=1 asynchronously forces all registers to 0, independent of clock.
  - While reset is high, no write occurs and both read ports return 0.
  - Reset asserted mid-cycle clears the registers immediately; a write pending on that edge is dropped.
- Write:
  - On the rising edge of clock, if reset=0, enWriteReg=1 and selWriteReg!=0, then r[selWriteReg] <= WriteData.
  - Writes with enWriteReg=0 are ignored.
  - Writes to index 0 are ignored; r0 always reads 0.
- Read:
  - Purely combinational, zero latency.
  - ReadDataN = 0 if selReadRegN==0.
  - Otherwise ReadDataN = WriteData if enWriteReg=1, selWriteReg==selReadRegN and reset=0 (bypass).
  - Otherwise ReadDataN = r[selReadRegN].
- Both read ports are independent; they may select the same register and return identical values.
- Bypass applies to either or both ports simultaneously.
- Back-to-back writes to the same register on consecutive edges: the last write wins.
- No X propagation after reset: every register holds a defined value.
- Outputs update within the same delta/combinational path when any select, WriteData or enWriteReg changes.

Test Plan:
- Reset: assert reset=1 for 2 cycles, sel1=1, sel2=2 -> ReadData1=0, ReadData2=0; assert reset mid-clock-high phase -> registers cleared immediately, no edge needed.
- Basic write/read:
  - Release reset; sel1=1, sel2=2, selWriteReg=2, WriteData=25, enWriteReg=1 -> ReadData2=25 immediately (bypass).
  - After the rising edge and enWriteReg=0 -> ReadData2 stays 25; ReadData1=0.
- Write disabled: enWriteReg=0, selWriteReg=5, WriteData=0xDEADBEEF, one edge, sel1=5 -> ReadData1=0.
- r0 hardwired: enWriteReg=1, selWriteReg=0, WriteData=0xFFFFFFFF, edge, sel1=0, sel2=0 -> both read 0, including during the bypass window.
- Full sweep:
  - Write r[i]=i*3+1 for i=1..31 on consecutive edges; then read all pairs (i, 31-i) -> each port returns its index value.
  - Overwrite r7=0x12345678 then r7=0x0BADF00D on consecutive edges -> sel1=7 returns 0x0BADF00D.
- Async reset after data: with the sweep contents loaded, pulse reset for 5 ns between edges -> all reads return 0 immediately and remain 0 after the next edge with enWriteReg=0.
